// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low {a..g} glyph table and its inverse decode.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_PATTERNS [0:15] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   typedef struct packed {
      logic       bad;
      logic       blank;
      logic [3:0] nibble;
   } seg7_dec_t;

   // Unknown glyphs decode as bad with nibble 0; an all-dark digit is a legal blank.
   function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
      seg7_dec_t r;
      r.bad    = 1'b1;
      r.blank  = 1'b0;
      r.nibble = 4'h0;
      if (pat == SEG_BLANK) begin
         r.bad   = 1'b0;
         r.blank = 1'b1;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (pat == SEG_PATTERNS[i]) begin
               r.bad    = 1'b0;
               r.nibble = 4'(i);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic       bad_o,
   output logic       blank_o,
   output logic [3:0] nibble_o
);

   seg7_dec_t dec_s;

   always_comb begin
      dec_s    = seg7_decode(pattern_i);
      bad_o    = dec_s.bad;
      blank_o  = dec_s.blank;
      nibble_o = dec_s.nibble;
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the displayed hex word,
// committing it only after STABLE_SCANS identical, fully decodable frames.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int SETTLE       = 4,
   parameter int STABLE_SCANS = 2
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [6:0]              seg,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic                    value_valid,
   output logic                    frame_err
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W   = $clog2(SETTLE + 1);
   localparam int MATCH_W = $clog2(STABLE_SCANS + 1);

   logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
   logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    cap_vld_q;
   logic [IDX_W-1:0]        cap_idx_q, idx_s;
   logic [6:0]              cap_seg_q;
   logic                    stable_s, cap_fire_s;

   logic                    dec_bad_s, dec_blank_s;
   logic [3:0]              dec_nib_s;

   logic [4*NUM_DIGITS-1:0] dig_buf_q, prev_val_q, value_q;
   logic [NUM_DIGITS-1:0]   blank_buf_q, bad_buf_q, prev_blank_q, blank_q;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [MATCH_W-1:0]      match_q, match_d;
   logic                    committed_q, valid_q, ferr_q;
   logic                    frame_s, commit_s, ferr_d;

   seg7_pattern_decode u_decode (
      .pattern_i (cap_seg_q),
      .bad_o     (dec_bad_s),
      .blank_o   (dec_blank_s),
      .nibble_o  (dec_nib_s)
   );

   // Dwell qualification: a digit counts only while exactly one anode is low and nothing moves.
   always_comb begin
      stable_s = ({an_s2_q, seg_s2_q} == {an_prev_q, seg_prev_q}) && $onehot(~an_s2_q);
      if (!stable_s) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(SETTLE)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      cap_fire_s = (cnt_d == CNT_W'(SETTLE - 1));
      idx_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         idx_s = (!an_s2_q[i]) ? IDX_W'(i) : idx_s;
      end
   end

   // Frame bookkeeping: a capture in the completing cycle seeds the freshly cleared mask.
   always_comb begin
      frame_s  = &seen_q;
      match_d  = match_q;
      ferr_d   = 1'b0;
      commit_s = 1'b0;
      if (frame_s) begin
         if (|bad_buf_q) begin
            ferr_d  = 1'b1;
            match_d = '0;
         end else if ((dig_buf_q == prev_val_q) && (blank_buf_q == prev_blank_q)) begin
            match_d = (match_q == MATCH_W'(STABLE_SCANS)) ? match_q : match_q + MATCH_W'(1);
         end else begin
            match_d = MATCH_W'(1);
         end
         commit_s = !(|bad_buf_q) && (match_d == MATCH_W'(STABLE_SCANS)) &&
                    (!committed_q || (dig_buf_q != value_q) || (blank_buf_q != blank_q));
      end else begin
         match_d = match_q;
      end
      seen_d = frame_s ? '0 : seen_q;
      if (cap_vld_q) begin
         seen_d = seen_d | (NUM_DIGITS'(1) << cap_idx_q);
      end else begin
         seen_d = seen_d;
      end
   end

   // Input synchronizers, settle counter and capture register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_s1_q    <= '0;
         an_s2_q    <= '0;
         an_prev_q  <= '0;
         seg_s1_q   <= '0;
         seg_s2_q   <= '0;
         seg_prev_q <= '0;
         cnt_q      <= '0;
         cap_vld_q  <= 1'b0;
         cap_idx_q  <= '0;
         cap_seg_q  <= '0;
      end else begin
         an_s1_q    <= an;
         an_s2_q    <= an_s1_q;
         an_prev_q  <= an_s2_q;
         seg_s1_q   <= seg;
         seg_s2_q   <= seg_s1_q;
         seg_prev_q <= seg_s2_q;
         cnt_q      <= cnt_d;
         cap_vld_q  <= cap_fire_s;
         if (cap_fire_s) begin
            cap_idx_q <= idx_s;
            cap_seg_q <= seg_s2_q;
         end
      end
   end

   // Digit buffers, frame history, match counter and committed outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dig_buf_q    <= '0;
         blank_buf_q  <= '0;
         bad_buf_q    <= '0;
         seen_q       <= '0;
         prev_val_q   <= '0;
         prev_blank_q <= '0;
         match_q      <= '0;
         committed_q  <= 1'b0;
         value_q      <= '0;
         blank_q      <= '0;
         valid_q      <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         seen_q  <= seen_d;
         match_q <= match_d;
         valid_q <= commit_s;
         ferr_q  <= ferr_d;
         if (cap_vld_q) begin
            dig_buf_q[int'(cap_idx_q)*4 +: 4] <= dec_nib_s;
            blank_buf_q[cap_idx_q]            <= dec_blank_s;
            bad_buf_q[cap_idx_q]              <= dec_bad_s;
         end
         if (frame_s) begin
            prev_val_q   <= dig_buf_q;
            prev_blank_q <= blank_buf_q;
         end
         if (commit_s) begin
            value_q     <= dig_buf_q;
            blank_q     <= blank_buf_q;
            committed_q <= 1'b1;
         end
      end
   end

   assign value       = value_q;
   assign blank       = blank_q;
   assign value_valid = valid_q;
   assign frame_err   = ferr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a 4-digit bus driven like a display scanner.
module tb_seg7_scan_decoder;

   logic        clk;
   logic        reset;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [15:0] value;
   logic [3:0]  blank;
   logic        value_valid;
   logic        frame_err;

   int errors = 0;
   int checks = 0;
   int vv_cnt = 0;
   int fe_cnt = 0;
   int base_vv;
   int base_fe;

   seg7_scan_decoder #(.NUM_DIGITS(4), .SETTLE(4), .STABLE_SCANS(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .an          (an),
      .seg         (seg),
      .value       (value),
      .blank       (blank),
      .value_valid (value_valid),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset && value_valid) vv_cnt <= vv_cnt + 1;
      if (reset && frame_err)   fe_cnt <= fe_cnt + 1;
   end

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 7'b0000001;  4'h1: enc = 7'b1001111;
         4'h2: enc = 7'b0010010;  4'h3: enc = 7'b0000110;
         4'h4: enc = 7'b1001100;  4'h5: enc = 7'b0100100;
         4'h6: enc = 7'b0100000;  4'h7: enc = 7'b0001111;
         4'h8: enc = 7'b0000000;  4'h9: enc = 7'b0000100;
         4'hA: enc = 7'b0001000;  4'hB: enc = 7'b1100000;
         4'hC: enc = 7'b0110001;  4'hD: enc = 7'b1000010;
         4'hE: enc = 7'b0110000;  4'hF: enc = 7'b0111000;
         default: enc = 7'b1111111;
      endcase
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scans digits 0..ndig-1 then leaves the bus dark long enough for the pipeline to drain.
   task automatic scan_frame(input logic [15:0] val, input logic [3:0] blk, input logic [3:0] badm,
                             input int dwell, input int glitch, input int ndig);
      for (int d = 0; d < ndig; d++) begin
         seg = blk[d] ? 7'b1111111 : (badm[d] ? 7'b1010101 : enc(val[4*d +: 4]));
         an  = ~(4'b0001 << d);
         if (d == glitch) begin
            cycles(3);
            an = ~((4'b0001 << d) | (4'b0001 << ((d + 1) % 4)));
            cycles(5);
            an = ~(4'b0001 << d);
         end
         cycles(dwell);
      end
      an  = 4'b1111;
      seg = 7'b1111111;
      cycles(12);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      an    = 4'b1111;
      seg   = 7'b1111111;
      cycles(4);
      checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value got %h want 0000", value); end
      checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL reset_blank got %b want 0000", blank); end
      checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", value_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
      reset = 1'b1;
      cycles(3);
   endtask

   task automatic test_basic();
      base_vv = vv_cnt;
      scan_frame(16'h1A3F, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (vv_cnt - base_vv !== 0) begin errors++; $display("FAIL basic_one_frame pulses got %0d want 0", vv_cnt - base_vv); end
      scan_frame(16'h1A3F, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (value !== 16'h1A3F) begin errors++; $display("FAIL basic_value got %h want 1a3f", value); end
      checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL basic_blank got %b want 0000", blank); end
      checks++; if (vv_cnt - base_vv !== 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", vv_cnt - base_vv); end
      scan_frame(16'h1A3F, 4'b0000, 4'b0000, 10, -1, 4);
      scan_frame(16'h1A3F, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (vv_cnt - base_vv !== 1) begin errors++; $display("FAIL basic_no_repulse got %0d want 1", vv_cnt - base_vv); end
   endtask

   task automatic test_short_dwell();
      base_vv = vv_cnt;
      scan_frame(16'h5C0D, 4'b0000, 4'b0000, 3, -1, 4);
      scan_frame(16'h5C0D, 4'b0000, 4'b0000, 3, -1, 4);
      scan_frame(16'h5C0D, 4'b0000, 4'b0000, 3, -1, 4);
      checks++; if (vv_cnt - base_vv !== 0) begin errors++; $display("FAIL short_dwell_pulses got %0d want 0", vv_cnt - base_vv); end
      checks++; if (value !== 16'h1A3F) begin errors++; $display("FAIL short_dwell_value got %h want 1a3f", value); end
      scan_frame(16'h5C0D, 4'b0000, 4'b0000, 10, -1, 4);
      scan_frame(16'h5C0D, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (value !== 16'h5C0D) begin errors++; $display("FAIL long_dwell_value got %h want 5c0d", value); end
      checks++; if (vv_cnt - base_vv !== 1) begin errors++; $display("FAIL long_dwell_pulses got %0d want 1", vv_cnt - base_vv); end
   endtask

   task automatic test_blank();
      base_vv = vv_cnt;
      scan_frame(16'h00B5, 4'b0100, 4'b0000, 10, -1, 4);
      scan_frame(16'h00B5, 4'b0100, 4'b0000, 10, -1, 4);
      checks++; if (value !== 16'h00B5) begin errors++; $display("FAIL blank_value got %h want 00b5", value); end
      checks++; if (blank !== 4'b0100) begin errors++; $display("FAIL blank_mask got %b want 0100", blank); end
      checks++; if (vv_cnt - base_vv !== 1) begin errors++; $display("FAIL blank_pulses got %0d want 1", vv_cnt - base_vv); end
   endtask

   task automatic test_bad_digit();
      base_vv = vv_cnt;
      base_fe = fe_cnt;
      scan_frame(16'h1234, 4'b0000, 4'b0001, 10, -1, 4);
      checks++; if (fe_cnt - base_fe !== 1) begin errors++; $display("FAIL bad_ferr_first got %0d want 1", fe_cnt - base_fe); end
      scan_frame(16'h1234, 4'b0000, 4'b0001, 10, -1, 4);
      checks++; if (fe_cnt - base_fe !== 2) begin errors++; $display("FAIL bad_ferr_second got %0d want 2", fe_cnt - base_fe); end
      checks++; if (value !== 16'h00B5) begin errors++; $display("FAIL bad_value_held got %h want 00b5", value); end
      checks++; if (vv_cnt - base_vv !== 0) begin errors++; $display("FAIL bad_pulses got %0d want 0", vv_cnt - base_vv); end
   endtask

   task automatic test_glitch();
      base_vv = vv_cnt;
      scan_frame(16'h1234, 4'b0000, 4'b0000, 10, -1, 4);
      scan_frame(16'h1234, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (value !== 16'h1234) begin errors++; $display("FAIL glitch_pre_value got %h want 1234", value); end
      scan_frame(16'h1234, 4'b0000, 4'b0000, 10, 1, 4);
      checks++; if (vv_cnt - base_vv !== 1) begin errors++; $display("FAIL glitch_ignored got %0d want 1", vv_cnt - base_vv); end
      scan_frame(16'h1235, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (vv_cnt - base_vv !== 1) begin errors++; $display("FAIL glitch_one_frame got %0d want 1", vv_cnt - base_vv); end
      checks++; if (value !== 16'h1234) begin errors++; $display("FAIL glitch_mid_value got %h want 1234", value); end
      scan_frame(16'h1235, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (value !== 16'h1235) begin errors++; $display("FAIL glitch_new_value got %h want 1235", value); end
      checks++; if (vv_cnt - base_vv !== 2) begin errors++; $display("FAIL glitch_pulses got %0d want 2", vv_cnt - base_vv); end
   endtask

   task automatic test_reset_mid_frame();
      scan_frame(16'h9876, 4'b0000, 4'b0000, 10, -1, 3);
      reset = 1'b0;
      #1;
      checks++; if (value !== 16'h0000) begin errors++; $display("FAIL midrst_value got %h want 0000", value); end
      checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL midrst_blank got %b want 0000", blank); end
      checks++; if (value_valid !== 1'b0 || frame_err !== 1'b0) begin
         errors++; $display("FAIL midrst_pulses got %b%b want 00", value_valid, frame_err);
      end
      cycles(3);
      reset = 1'b1;
      cycles(3);
      base_vv = vv_cnt;
      scan_frame(16'h9876, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (vv_cnt - base_vv !== 0) begin errors++; $display("FAIL midrst_one_frame got %0d want 0", vv_cnt - base_vv); end
      checks++; if (value !== 16'h0000) begin errors++; $display("FAIL midrst_early_value got %h want 0000", value); end
      scan_frame(16'h9876, 4'b0000, 4'b0000, 10, -1, 4);
      checks++; if (value !== 16'h9876) begin errors++; $display("FAIL midrst_value_after got %h want 9876", value); end
      checks++; if (vv_cnt - base_vv !== 1) begin errors++; $display("FAIL midrst_pulses_after got %0d want 1", vv_cnt - base_vv); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_dwell();
      test_blank();
      test_bad_digit();
      test_glitch();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
